// File: rtl/des_ahb_master.sv
// AHB-Lite initiator that runs one Triple DES job through the slave register map and returns the result.
// Optional poll timeout: define DES_MASTER_TIMEOUT_EN (the limit is POLL_LIMIT).
module des_ahb_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_encrypt,
  input  logic [63:0] cmd_data,
  input  logic [63:0] cmd_key1,
  input  logic [63:0] cmd_key2,
  input  logic [63:0] cmd_key3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_error,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA
);

  // cmd and rsp are valid/ready: a transfer happens on the rising edge where both are high,
  // and the valid side holds its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t      state;
  logic [2:0]  step;
  logic [2:0]  next_step;
  logic        retry;
  logic        enc_q;
  logic [63:0] key1_q;
  logic [63:0] key2_q;
  logic [63:0] key3_q;
  logic [63:0] data_q;
  logic [63:0] operand;

  assign HSIZE     = 3'b011;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign cmd_ready = (state == IDLE) && HRESET;

  // Register offsets are step*8, so step 5 is the status word and step 6 the result.
  function automatic logic [31:0] step_addr(input logic [2:0] s);
    return BASE_ADDR + {26'd0, s, 3'd0};
  endfunction

  always_comb begin
    case (step)
      3'd0:    operand = key1_q;
      3'd1:    operand = key2_q;
      3'd2:    operand = key3_q;
      3'd3:    operand = data_q;
      3'd4:    operand = {62'd0, 1'b1, enc_q};
      default: operand = 64'd0;
    endcase
  end

  always_comb begin
    retry     = (step == 3'd5) && !HRDATA[0];
    next_step = retry ? step : step + 3'd1;
  end

`ifdef DES_MASTER_TIMEOUT_EN
  localparam int unsigned POLL_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;
  logic [POLL_W-1:0] poll_cnt;
  logic              poll_expired;
  // The poll just completing is the last one allowed when the counter sits one below the limit.
  assign poll_expired = retry && (poll_cnt == POLL_W'(POLL_LIMIT - 1));
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state     <= IDLE;
      step      <= 3'd0;
      HTRANS    <= TRANS_IDLE;
      HADDR     <= 32'd0;
      HWRITE    <= 1'b0;
      HWDATA    <= 64'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 64'd0;
      rsp_error <= 1'b0;
`ifdef DES_MASTER_TIMEOUT_EN
      poll_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            enc_q  <= cmd_encrypt;
            key1_q <= cmd_key1;
            key2_q <= cmd_key2;
            key3_q <= cmd_key3;
            data_q <= cmd_data;
            step   <= 3'd0;
            HTRANS <= TRANS_NONSEQ;
            HADDR  <= step_addr(3'd0);
            HWRITE <= 1'b1;
            state  <= ADDR;
`ifdef DES_MASTER_TIMEOUT_EN
            poll_cnt <= '0;
`endif
          end
        end
        ADDR: begin
          if (HREADY) begin
            HTRANS <= TRANS_IDLE;
            HWDATA <= operand;
            state  <= DATA;
          end
        end
        DATA: begin
          // HRESP only counts on the completing cycle; the first error cycle has HREADY low.
          if (HREADY) begin
            if (HRESP) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_data  <= 64'd0;
              state     <= RESP;
            end else if (step == 3'd6) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b0;
              rsp_data  <= HRDATA;
              state     <= RESP;
            end
`ifdef DES_MASTER_TIMEOUT_EN
            else if (poll_expired) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_data  <= 64'd0;
              state     <= RESP;
            end
`endif
            else begin
              step   <= next_step;
              HTRANS <= TRANS_NONSEQ;
              HADDR  <= step_addr(next_step);
              HWRITE <= (next_step < 3'd5);
              state  <= ADDR;
`ifdef DES_MASTER_TIMEOUT_EN
              if (retry) poll_cnt <= poll_cnt + 1'b1;
`endif
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_ahb_master.sv
// Directed bench for des_ahb_master with a behavioural AHB slave mimicking the Triple DES register map.
module tb_des_ahb_master;

  localparam logic [63:0] KEY     = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] PT      = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CT      = 64'h85E8_1354_0F0A_B405;
  localparam logic [63:0] BAD     = 64'hBAD0_BAD0_BAD0_BAD0;
  localparam logic [31:0] NO_ADDR = 32'hFFFF_FFFF;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_encrypt = 1'b0;
  logic [63:0] cmd_data = 64'd0;
  logic [63:0] cmd_key1 = 64'd0;
  logic [63:0] cmd_key2 = 64'd0;
  logic [63:0] cmd_key3 = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_error;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [63:0] HRDATA = 64'd0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  des_ahb_master #(.BASE_ADDR(32'h0000_0000), .POLL_LIMIT(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_encrypt(cmd_encrypt),
    .cmd_data(cmd_data), .cmd_key1(cmd_key1), .cmd_key2(cmd_key2), .cmd_key3(cmd_key3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  // Clock / cycle counter
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Slave model state and bus log
  logic [31:0] s_wait_addr = NO_ADDR;
  int          s_wait_n = 0;
  logic [31:0] s_err_addr = NO_ADDR;
  int          s_done_after = 1;
  int          s_polls = 0;
  logic [63:0] s_reg [0:4];
  logic [31:0] log_addr  [0:255];
  logic        log_write [0:255];
  logic [63:0] log_wdata [0:255];
  int          log_n = 0;
  int          stab_err = 0;
  int          pipe_err = 0;
  logic        dp_active = 1'b0;
  logic        dp_first = 1'b0;
  logic        dp_write = 1'b0;
  logic        dp_err = 1'b0;
  logic [31:0] dp_addr = 32'd0;
  int          dp_wait = 0;
  logic [31:0] cap_addr = 32'd0;
  logic [63:0] cap_wdata = 64'd0;

  function automatic logic [63:0] slave_result();
    if (s_reg[0] == KEY && s_reg[1] == KEY && s_reg[2] == KEY) begin
      if (s_reg[4][1:0] == 2'b11 && s_reg[3] == PT) return CT;
      if (s_reg[4][1:0] == 2'b10 && s_reg[3] == CT) return PT;
    end
    return BAD;
  endfunction

  // Slave drives its responses on the falling edge; the master samples them on the rising edge.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      dp_active = 1'b0;
      HREADY = 1'b1;
      HRESP = 1'b0;
      HRDATA = 64'd0;
    end else if (dp_active) begin
      if (HTRANS == 2'b10) pipe_err++;
      if (dp_first) begin
        cap_addr = HADDR;
        cap_wdata = HWDATA;
        dp_first = 1'b0;
      end else if (HADDR !== cap_addr || HWDATA !== cap_wdata) begin
        stab_err++;
      end
      if (dp_wait > 0) begin
        HREADY = 1'b0;
        HRESP = dp_err;
        dp_wait--;
      end else begin
        HREADY = 1'b1;
        HRESP = dp_err;
        dp_active = 1'b0;
        HRDATA = 64'd0;
        if (dp_write) begin
          log_wdata[log_n-1] = HWDATA;
          if (!dp_err && dp_addr[5:3] < 3'd5) s_reg[dp_addr[5:3]] = HWDATA;
        end else if (dp_addr[7:0] == 8'h28) begin
          s_polls++;
          HRDATA = {63'd0, (s_done_after != 0) && (s_polls >= s_done_after)};
        end else begin
          HRDATA = slave_result();
        end
      end
    end else if (HTRANS == 2'b10) begin
      HREADY = 1'b1;
      HRESP = 1'b0;
      log_addr[log_n] = HADDR;
      log_write[log_n] = HWRITE;
      log_wdata[log_n] = 64'd0;
      log_n++;
      dp_active = 1'b1;
      dp_first = 1'b1;
      dp_addr = HADDR;
      dp_write = HWRITE;
      dp_err = (HADDR == s_err_addr);
      dp_wait = dp_err ? 1 : ((HADDR == s_wait_addr) ? s_wait_n : 0);
    end else begin
      HREADY = 1'b1;
      HRESP = 1'b0;
    end
  end

  // Driver tasks
  task automatic clear_slave(input logic [31:0] wait_addr, input int wait_n,
                             input logic [31:0] err_addr, input int done_after);
    s_wait_addr = wait_addr;
    s_wait_n = wait_n;
    s_err_addr = err_addr;
    s_done_after = done_after;
    s_polls = 0;
    log_n = 0;
    stab_err = 0;
    pipe_err = 0;
  endtask

  task automatic start_job(input logic enc, input logic [63:0] data, output int acc);
    @(posedge HCLK); #1;
    cmd_valid = 1'b1;
    cmd_encrypt = enc;
    cmd_data = data;
    cmd_key1 = KEY;
    cmd_key2 = KEY;
    cmd_key3 = KEY;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      if (cmd_ready) begin
        @(posedge HCLK); #1;
        acc = cyc;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (acc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready never high, required within 20 cycles");
    end
  endtask

  task automatic wait_rsp(input int acc, input int max, output int lat);
    lat = -1;
    for (int i = 0; i < max; i++) begin
      @(posedge HCLK); #1;
      if (rsp_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid, required within %0d cycles", max);
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge HCLK); #1;
    rsp_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    n_cmp++; if (HTRANS !== 2'b00 || HADDR !== 32'd0 || HWRITE !== 1'b0 || HWDATA !== 64'd0) begin
      n_fail++; $display("FAIL reset_bus: got htrans=%b haddr=%h hwrite=%b hwdata=%h, required all zero", HTRANS, HADDR, HWRITE, HWDATA);
    end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 64'd0 || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: got valid=%b data=%h error=%b, required all zero", rsp_valid, rsp_data, rsp_error);
    end
    n_cmp++; if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready);
    end
    n_cmp++; if (HSIZE !== 3'b011 || HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
      n_fail++; $display("FAIL const_outputs: got hsize=%b hburst=%b hprot=%b lock=%b, required 011 000 0011 0", HSIZE, HBURST, HPROT, HMASTLOCK);
    end
    HRESET = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_cmd_ready: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_encrypt();
    int acc, lat;
    logic [63:0] ewd [0:4];
    ewd[0] = KEY; ewd[1] = KEY; ewd[2] = KEY; ewd[3] = PT; ewd[4] = 64'h3;
    clear_slave(NO_ADDR, 0, NO_ADDR, 1);
    start_job(1'b1, PT, acc);
    wait_rsp(acc, 100, lat);
    n_cmp++; if (lat !== 14) begin
      n_fail++; $display("FAIL enc_latency: got %0d, required 14", lat);
    end
    n_cmp++; if (rsp_data !== CT || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL enc_rsp: got data=%h error=%b, required data=%h error=0", rsp_data, rsp_error, CT);
    end
    n_cmp++; if (log_n !== 7) begin
      n_fail++; $display("FAIL enc_transfer_count: got %0d, required 7", log_n);
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (log_addr[i] !== 32'(i * 8) || log_write[i] !== (i < 5)) begin
        n_fail++; $display("FAIL enc_bus[%0d]: got addr=%h write=%b, required addr=%h write=%b", i, log_addr[i], log_write[i], 32'(i * 8), (i < 5));
      end
      if (i < 5) begin
        n_cmp++; if (log_wdata[i] !== ewd[i]) begin
          n_fail++; $display("FAIL enc_wdata[%0d]: got %h, required %h", i, log_wdata[i], ewd[i]);
        end
      end
    end
    ack_rsp();
    n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL enc_handshake: got rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_decrypt();
    int acc, lat;
    clear_slave(NO_ADDR, 0, NO_ADDR, 1);
    start_job(1'b0, CT, acc);
    wait_rsp(acc, 100, lat);
    n_cmp++; if (lat !== 14) begin
      n_fail++; $display("FAIL dec_latency: got %0d, required 14", lat);
    end
    n_cmp++; if (rsp_data !== PT || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL dec_rsp: got data=%h error=%b, required data=%h error=0", rsp_data, rsp_error, PT);
    end
    n_cmp++; if (log_addr[4] !== 32'h20 || log_wdata[4] !== 64'h2) begin
      n_fail++; $display("FAIL dec_control: got addr=%h wdata=%h, required addr=00000020 wdata=%h", log_addr[4], log_wdata[4], 64'h2);
    end
    ack_rsp();
  endtask

  task automatic test_wait_states();
    int acc, lat;
    clear_slave(32'h08, 3, NO_ADDR, 3);
    start_job(1'b1, PT, acc);
    wait_rsp(acc, 100, lat);
    n_cmp++; if (lat !== 21) begin
      n_fail++; $display("FAIL wait_latency: got %0d, required 21", lat);
    end
    n_cmp++; if (stab_err !== 0 || pipe_err !== 0) begin
      n_fail++; $display("FAIL wait_stability: got unstable=%0d pipelined=%0d, required 0 0", stab_err, pipe_err);
    end
    n_cmp++; if (log_n !== 9 || log_wdata[1] !== KEY) begin
      n_fail++; $display("FAIL wait_bus: got transfers=%0d key2=%h, required 9 %h", log_n, log_wdata[1], KEY);
    end
    n_cmp++; if (rsp_data !== CT || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL wait_rsp: got data=%h error=%b, required data=%h error=0", rsp_data, rsp_error, CT);
    end
    ack_rsp();
  endtask

  task automatic test_error();
    int acc, lat;
    clear_slave(NO_ADDR, 0, 32'h18, 1);
    start_job(1'b1, PT, acc);
    wait_rsp(acc, 100, lat);
    n_cmp++; if (lat !== 9) begin
      n_fail++; $display("FAIL err_latency: got %0d, required 9", lat);
    end
    n_cmp++; if (rsp_error !== 1'b1 || rsp_data !== 64'd0) begin
      n_fail++; $display("FAIL err_rsp: got data=%h error=%b, required data=0 error=1", rsp_data, rsp_error);
    end
    repeat (4) @(posedge HCLK);
    #1;
    n_cmp++; if (log_n !== 4 || log_addr[3] !== 32'h18 || HTRANS !== 2'b00) begin
      n_fail++; $display("FAIL err_no_more: got transfers=%0d last=%h htrans=%b, required 4 00000018 00", log_n, log_addr[3], HTRANS);
    end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin
      n_fail++; $display("FAIL err_hold: got valid=%b error=%b, required 1 1", rsp_valid, rsp_error);
    end
    ack_rsp();
  endtask

  task automatic test_timeout();
    int acc, lat, polls;
`ifdef DES_MASTER_TIMEOUT_EN
    clear_slave(NO_ADDR, 0, NO_ADDR, 0);
    start_job(1'b1, PT, acc);
    wait_rsp(acc, 100, lat);
    polls = 0;
    for (int i = 0; i < log_n; i++) if (log_addr[i] == 32'h28) polls++;
    n_cmp++; if (polls !== 4 || log_n !== 9) begin
      n_fail++; $display("FAIL timeout_polls: got polls=%0d transfers=%0d, required 4 9", polls, log_n);
    end
    n_cmp++; if (lat !== 18 || rsp_error !== 1'b1 || rsp_data !== 64'd0) begin
      n_fail++; $display("FAIL timeout_rsp: got lat=%0d error=%b data=%h, required 18 1 0", lat, rsp_error, rsp_data);
    end
`else
    clear_slave(NO_ADDR, 0, NO_ADDR, 101);
    start_job(1'b1, PT, acc);
    wait_rsp(acc, 400, lat);
    polls = 0;
    for (int i = 0; i < log_n; i++) if (log_addr[i] == 32'h28) polls++;
    n_cmp++; if (polls !== 101) begin
      n_fail++; $display("FAIL unbounded_polls: got %0d, required 101", polls);
    end
    n_cmp++; if (lat !== 214 || rsp_error !== 1'b0 || rsp_data !== CT) begin
      n_fail++; $display("FAIL unbounded_rsp: got lat=%0d error=%b data=%h, required 214 0 %h", lat, rsp_error, rsp_data, CT);
    end
`endif
    ack_rsp();
  endtask

  task automatic test_reset_mid_job();
    int acc, lat, seen;
    bit hit;
    clear_slave(NO_ADDR, 0, NO_ADDR, 0);
    start_job(1'b1, PT, acc);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge HCLK); #1;
      if (log_n >= 6) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_cmp++; n_fail++;
      $display("FAIL poll_start_timeout: no status poll within 50 cycles");
    end
    HRESET = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_cmd_ready_low: got %b, required 0", cmd_ready);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    #1;
    n_cmp++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_state: got htrans=%b rsp_valid=%b cmd_ready=%b, required 00 0 1", HTRANS, rsp_valid, cmd_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge HCLK); #1;
      if (rsp_valid || HTRANS != 2'b00) seen++;
    end
    n_cmp++; if (seen !== 0) begin
      n_fail++; $display("FAIL midrst_discard: got %0d active cycles, required 0", seen);
    end
    clear_slave(NO_ADDR, 0, NO_ADDR, 1);
    start_job(1'b1, PT, acc);
    wait_rsp(acc, 100, lat);
    n_cmp++; if (lat !== 14 || rsp_data !== CT || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL midrst_next_job: got lat=%0d data=%h error=%b, required 14 %h 0", lat, rsp_data, rsp_error, CT);
    end
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, lat, n;
    clear_slave(NO_ADDR, 0, NO_ADDR, 1);
    @(posedge HCLK); #1;
    cmd_valid = 1'b1; cmd_encrypt = 1'b1; cmd_data = PT;
    cmd_key1 = KEY; cmd_key2 = KEY; cmd_key3 = KEY;
    rsp_ready = 1'b1;
    acc1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      if (cmd_ready) begin
        @(posedge HCLK); #1;
        acc1 = cyc;
        break;
      end
    end
    if (acc1 < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL b2b_accept_timeout: cmd_ready never high within 20 cycles");
    end
    cmd_encrypt = 1'b0;
    cmd_data = CT;
    @(posedge HCLK); #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy_ready: got %b, required 0", cmd_ready);
    end
    wait_rsp(acc1 - 1, 100, lat);
    n_cmp++; if (lat !== 15 || rsp_data !== CT) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d data=%h, required 14 %h", lat - 1, rsp_data, CT);
    end
    @(posedge HCLK); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: got rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
    @(posedge HCLK); #1;
    acc2 = cyc;
    n = log_n;
    cmd_valid = 1'b0;
    n_cmp++; if (HTRANS !== 2'b10 || HADDR !== 32'h0 || cmd_ready !== 1'b0 || n !== 7) begin
      n_fail++; $display("FAIL b2b_second_accept: got htrans=%b haddr=%h cmd_ready=%b prior=%0d, required 10 00000000 0 7", HTRANS, HADDR, cmd_ready, n);
    end
    wait_rsp(acc2, 100, lat);
    n_cmp++; if (lat !== 14 || rsp_data !== PT || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d data=%h error=%b, required 14 %h 0", lat, rsp_data, rsp_error, PT);
    end
    @(posedge HCLK); #1;
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_final_ack: got rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_wait_states();
    test_error();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/des_ahb_master.md
# des_ahb_master

AHB-Lite bus initiator that drives the Triple DES slave from a simple command/response interface. It accepts one job (three keys, one data block, direction), writes it into the slave's register map, polls the slave status until the operation completes, reads back the result, and returns it with an error flag. It sits on the master side of the same AHB-Lite bus that the Triple DES slave and the default slave decode.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, base of the Triple DES register map.
- POLL_LIMIT, 255, maximum status polls per job; used only with DES_MASTER_TIMEOUT_EN.

Ports:
- HCLK  in  1  clock, all logic on rising edge.
- HRESET  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  job offered.
- cmd_ready  out  1  job accepted when high with cmd_valid.
- cmd_encrypt  in  1  1 = encrypt, 0 = decrypt.
- cmd_data, cmd_key1, cmd_key2, cmd_key3  in  64 each  operand block and keys.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed when high with rsp_valid.
- rsp_data  out  64  result block.
- rsp_error  out  1  job ended on HRESP error or poll timeout.
- HADDR  out  32; HWRITE  out  1; HTRANS  out  2; HSIZE  out  3; HBURST  out  3; HPROT  out  4; HMASTLOCK  out  1; HWDATA  out  64.
- HREADY  in  1; HRESP  in  1; HRDATA  in  64.

## Operation
- Register map (offset from BASE_ADDR): 0x00 key1, 0x08 key2, 0x10 key3, 0x18 data, 0x20 control (bit1 start, bit0 encrypt), 0x28 status (bit0 done, read), 0x30 result (read).
- Constant outputs: HSIZE=3'b011, HBURST=3'b000, HPROT=4'b0011, HMASTLOCK=0.
- Step index 0..6: writes to 0x00, 0x08, 0x10, 0x18, 0x20 (HWDATA = {62'b0, 1'b1, encrypt}); read 0x28 (poll); read 0x30.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready latch all cmd fields, step=0, poll count=0, go ADDR.
- ADDR: HTRANS=NONSEQ (2'b10), HADDR=BASE_ADDR+offset(step), HWRITE=1 for steps 0-4 else 0. Hold stable while HREADY=0; on edge with HREADY=1 go DATA.
- DATA: HTRANS=IDLE, HWDATA=operand for step (held through wait states). On edge with HREADY=1:
  - HRESP=1: rsp_error=1, rsp_data=0, go RESP.
  - steps 0-3: step+1, ADDR. Step 4: step=5, ADDR.
  - step 5: HRDATA[0]=1 -> step=6, ADDR; else poll count+1, stay step 5, ADDR.
  - step 6: rsp_data=HRDATA, rsp_error=0, go RESP.
- RESP: rsp_valid=1, rsp_data/rsp_error stable; on rsp_ready go IDLE.
- Non-pipelined: never issues a new address phase during a data phase.

## Timing
- While HRESET=0 at an edge: state IDLE; outputs HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_data=0, rsp_error=0. cmd_ready=0 while HRESET=0, 1 in IDLE otherwise.
- Reset mid-job: job discarded, HTRANS=IDLE from the following cycle, no response produced.
- Each transfer with a zero-wait slave: 2 cycles. Latency from acceptance edge to rsp_valid = 2×(6+P) cycles, P = polls (≥1); P=1 gives 14. Each HREADY=0 cycle adds one.
- cmd_valid during non-IDLE states ignored (cmd_ready=0). rsp_ready before rsp_valid ignored.
- HRESP sampled only when HREADY=1 in DATA (second cycle of an AHB error response).
- Back-to-back jobs: IDLE re-entered on rsp handshake edge; next job acceptable one cycle later.

## Configuration
- DES_MASTER_TIMEOUT_EN defined: if poll count reaches POLL_LIMIT with done still 0, go RESP with rsp_error=1, rsp_data=0 instead of polling again.
- Undefined: polling unbounded; no poll counter is built; POLL_LIMIT unused.

## Test plan
- Encrypt, key1=key2=key3=64'h133457799BBCDFF1, data=64'h0123456789ABCDEF, zero-wait slave -> bus shows 5 writes at 0x00..0x20 (control HWDATA=64'h3), polls, read 0x30; rsp_data=64'h85E813540F0AB405, rsp_error=0.
- Decrypt same keys, data=64'h85E813540F0AB405 -> rsp_data=64'h0123456789ABCDEF, control HWDATA=64'h2.
- Slave model inserts 3 wait states on key2 write and done on third poll -> HADDR/HWDATA held stable during waits; rsp_valid 14+3+4=21 cycles after acceptance.
- Slave returns two-cycle HRESP error on data write (0x18) -> no further transfers, rsp_valid=1, rsp_error=1, rsp_data=0.
- With DES_MASTER_TIMEOUT_EN, POLL_LIMIT=4, done never set -> exactly 4 reads of 0x28, then rsp_error=1; without macro, polling continues after 100 polls.
- HRESET=0 for one cycle during poll phase -> next cycle HTRANS=2'b00, rsp_valid=0, cmd_ready=1 after reset release; new job completes normally.
